dec_scan_ctrl: RTL



---
 rtl/dec_scan_ctrl_pkg.sv | 15 +
 rtl/dec_scan_ctrl_if.sv | 28 ++
 rtl/dec_scan_ctrl_lane_next_sel.sv | 31 +++
 rtl/dec_scan_ctrl.sv | 115 +++++++++++
 4 files changed

// File: rtl/dec_scan_ctrl_pkg.sv
// Shared definitions for the decoder scan sequencer: lane geometry and FSM states.
package dec_scan_ctrl_pkg;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 2;

    typedef logic [LANE_W-1:0] lane_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_BLANK  = 2'd2
    } state_t;

endpackage

// File: rtl/dec_scan_ctrl_if.sv
// Control/status bundle between a scan requester and the decoder scan sequencer.
interface dec_scan_ctrl_if #(
    parameter int DWELL_W = 8
);
    import dec_scan_ctrl_pkg::*;

    logic                   start;
    logic                   stop;
    logic                   mode;
    logic [0:NUM_LANES-1]   mask;
    logic [DWELL_W-1:0]     dwell;
    lane_t                  w;
    logic                   en;
    logic                   busy;
    logic                   done;
    logic                   wrap;

    modport master (
        output start, stop, mode, mask, dwell,
        input  w, en, busy, done, wrap
    );

    modport slave (
        input  start, stop, mode, mask, dwell,
        output w, en, busy, done, wrap
    );

endinterface

// File: rtl/dec_scan_ctrl_lane_next_sel.sv
// Picks the next enabled lane above the current one, or wraps to the lowest enabled lane.
module lane_next_sel
    import dec_scan_ctrl_pkg::*;
(
    input  logic [0:NUM_LANES-1] mask,
    input  lane_t                cur,
    output lane_t                next,
    output logic                 wrapped,
    output lane_t                first
);

    always_comb begin
        first   = '0;
        next    = '0;
        wrapped = 1'b1;
        // Scanning downward leaves the lowest qualifying index as the winner.
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                first = lane_t'(i);
            end
            if (mask[i] && (i > int'(cur))) begin
                next    = lane_t'(i);
                wrapped = 1'b0;
            end
        end
        if (wrapped) begin
            next = first;
        end
    end

endmodule

// File: rtl/dec_scan_ctrl.sv
// Break-before-make scan sequencer driving the select and enable of a 2-to-4 decoder.
module dec_scan_ctrl
    import dec_scan_ctrl_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic            clock,
    input  logic            reset,
    dec_scan_ctrl_if.slave  bus
);

    state_t               state;
    logic                 mode_q;
    logic [0:NUM_LANES-1] mask_q;
    logic [DWELL_W-1:0]   dwell_q;
    logic [DWELL_W-1:0]   cnt;
    lane_t                w_q;
    logic                 en_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 wrap_q;

    logic [0:NUM_LANES-1] sel_mask;
    lane_t                next_lane;
    lane_t                first_lane;
    logic                 wrapped;

    // In IDLE the live mask chooses the first lane; once scanning, only the latched copy matters.
    assign sel_mask = (state == ST_IDLE) ? bus.mask : mask_q;

    lane_next_sel u_sel (
        .mask    (sel_mask),
        .cur     (w_q),
        .next    (next_lane),
        .wrapped (wrapped),
        .first   (first_lane)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            mode_q  <= 1'b0;
            mask_q  <= '0;
            dwell_q <= '0;
            cnt     <= '0;
            w_q     <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            wrap_q <= 1'b0;
            if ((state != ST_IDLE) && bus.stop) begin
                state  <= ST_IDLE;
                w_q    <= '0;
                en_q   <= 1'b0;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.start && !bus.stop && (bus.mask != '0)) begin
                            state   <= ST_ACTIVE;
                            mode_q  <= bus.mode;
                            mask_q  <= bus.mask;
                            dwell_q <= bus.dwell;
                            cnt     <= bus.dwell;
                            w_q     <= first_lane;
                            en_q    <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                    ST_ACTIVE: begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else if (!wrapped) begin
                            state <= ST_BLANK;
                            w_q   <= next_lane;
                            en_q  <= 1'b0;
                        end else if (mode_q) begin
                            state  <= ST_IDLE;
                            w_q    <= '0;
                            en_q   <= 1'b0;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            state  <= ST_BLANK;
                            w_q    <= next_lane;
                            en_q   <= 1'b0;
                            wrap_q <= 1'b1;
                        end
                    end
                    ST_BLANK: begin
                        state <= ST_ACTIVE;
                        cnt   <= dwell_q;
                        en_q  <= 1'b1;
                    end
                    default: begin
                        state  <= ST_IDLE;
                        w_q    <= '0;
                        en_q   <= 1'b0;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.w    = w_q;
    assign bus.en   = en_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.wrap = wrap_q;

endmodule
